// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg -- shared types for the memory stage: data word, MEM-stage FSM states, alignment mask.
// Revision 1.0
`default_nettype none

package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2,
    HALTED = 2'd3
  } memstate_t;

  localparam logic [1:0] c_MISALIGN_MASK = 2'b11;

endpackage

`default_nettype wire

// File: rtl/mem_wait_watchdog.sv
// mem_wait_watchdog -- counts cache wait cycles and flags the cycle in which the wait limit is reached.
// Revision 1.0
`default_nettype none

module mem_wait_watchdog #(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic CLK,
  input  logic nRST,
  input  logic en_i,
  input  logic clr_i,
  output logic timeout_o
);

  localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WAIT_LIMIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // The counter holds the number of waits already seen, so the limit-th waiting cycle trips here.
  assign timeout_o = en_i & (cnt_q == c_LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || timeout_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl -- MEM-stage controller: dcache request/hit handshake, stall, MEM/WB completion strobe.
// Revision 1.0
`default_nettype none

module mem_stage_ctrl
  import cpu_types_pkg::*;
#(
  parameter int WAIT_LIMIT = 255,
  parameter int CNT_W      = 8
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        valid_in,
  input  logic        dren_in,
  input  logic        dwen_in,
  input  logic        halt_in,
  input  logic        flush,
  input  logic [31:0] addr_in,
  input  logic [31:0] store_in,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        stall,
  output logic        mem_done,
  output logic [31:0] dMemLoad,
  output logic        halt,
  output logic        err_misaligned,
  output logic        err_timeout,
  output logic        err_protocol
);

  memstate_t state_q, state_d;
  word_t     addr_q, addr_d;
  word_t     data_q, data_d;
  word_t     load_q, load_d;
  logic      ren_q, ren_d;
  logic      wen_q, wen_d;
  logic      halt_q, halt_d;
  logic      mis_q, mis_d;
  logic      to_q, to_d;
  logic      pr_q, pr_d;

  logic      w_memop;
  logic      w_misal;
  logic      w_live;
  logic      w_wd_en;
  logic      w_wd_clr;
  logic      w_timeout;

  assign w_memop  = dren_in | dwen_in;
  assign w_misal  = |(addr_in[1:0] & c_MISALIGN_MASK);
  assign w_live   = valid_in & ~flush;
  assign w_wd_en  = (state_q == ACCESS) & ~dhit;
  assign w_wd_clr = (state_q != ACCESS) | dhit;

  mem_wait_watchdog #(
    .WAIT_LIMIT (WAIT_LIMIT),
    .CNT_W      (CNT_W)
  ) u_watchdog (
    .CLK       (CLK),
    .nRST      (nRST),
    .en_i      (w_wd_en),
    .clr_i     (w_wd_clr),
    .timeout_o (w_timeout)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    load_d    = load_q;
    ren_d     = ren_q;
    wen_d     = wen_q;
    halt_d    = halt_q;
    mis_d     = mis_q;
    to_d      = to_q;
    pr_d      = pr_q;
    stall     = 1'b0;
    mem_done  = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    dmemaddr  = '0;
    dmemstore = '0;

    case (state_q)
      IDLE: begin
        if (w_live) begin
          if (w_memop) begin
            stall = 1'b1;
            if (dren_in && dwen_in) begin
              pr_d = 1'b1;
            end
            if (w_misal) begin
              mis_d   = 1'b1;
              load_d  = '0;
              state_d = DONE;
            end else begin
              addr_d  = addr_in;
              data_d  = store_in;
              wen_d   = dwen_in;
              ren_d   = ~dwen_in;
              state_d = ACCESS;
            end
          end else if (halt_in) begin
            mem_done = 1'b1;
            halt_d   = 1'b1;
            state_d  = HALTED;
          end else begin
            mem_done = 1'b1;
          end
        end
      end

      ACCESS: begin
        stall     = 1'b1;
        dmemREN   = ren_q;
        dmemWEN   = wen_q;
        dmemaddr  = addr_q;
        dmemstore = data_q;
        if (dhit) begin
          if (ren_q) begin
            load_d = dmemload;
          end
          state_d = DONE;
        end else if (w_timeout) begin
          to_d    = 1'b1;
          load_d  = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        mem_done = 1'b1;
        state_d  = IDLE;
      end

      HALTED: begin
        state_d = HALTED;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      load_q  <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      halt_q  <= 1'b0;
      mis_q   <= 1'b0;
      to_q    <= 1'b0;
      pr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      load_q  <= load_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      halt_q  <= halt_d;
      mis_q   <= mis_d;
      to_q    <= to_d;
      pr_q    <= pr_d;
    end
  end

  assign dMemLoad       = load_q;
  assign halt           = halt_q;
  assign err_misaligned = mis_q;
  assign err_timeout    = to_q;
  assign err_protocol   = pr_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl -- scoreboard bench for mem_stage_ctrl with WAIT_LIMIT = 4.
// Revision 1.0
`default_nettype none

module tb_mem_stage_ctrl;
  import cpu_types_pkg::*;

  localparam int WL = 4;

  logic  CLK = 1'b0;
  logic  nRST = 1'b0;
  logic  valid_in = 1'b0, dren_in = 1'b0, dwen_in = 1'b0, halt_in = 1'b0, flush = 1'b0;
  logic  dhit = 1'b0;
  word_t addr_in = '0, store_in = '0, dmemload = 32'hDEAD_BEEF;
  logic  dmemREN, dmemWEN, stall, mem_done, halt;
  logic  err_misaligned, err_timeout, err_protocol;
  word_t dmemaddr, dmemstore, dMemLoad;

  always #5 CLK = ~CLK;

  mem_stage_ctrl #(.WAIT_LIMIT(WL), .CNT_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .valid_in(valid_in), .dren_in(dren_in), .dwen_in(dwen_in),
    .halt_in(halt_in), .flush(flush), .addr_in(addr_in), .store_in(store_in),
    .dhit(dhit), .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .stall(stall), .mem_done(mem_done),
    .dMemLoad(dMemLoad), .halt(halt), .err_misaligned(err_misaligned),
    .err_timeout(err_timeout), .err_protocol(err_protocol)
  );

  typedef struct packed {
    word_t ld;
    logic  mis;
    logic  to;
    logic  pr;
  } exp_t;

  exp_t  sb[$];
  int    total = 0, bad = 0, cyc = 0;
  int    stall_cnt = 0, ren_cnt = 0, wen_cnt = 0, done_cnt = 0, stall_start = 0, done_cyc = 0;
  word_t exp_addr = '0, exp_store = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Monitor: request/stall bookkeeping and scoreboard pop on every completion strobe.
  always @(negedge CLK) begin
    cyc++;
    if (nRST) begin
      if (stall) begin
        if (stall_cnt == 0) stall_start = cyc;
        stall_cnt++;
      end
      if (dmemREN) ren_cnt++;
      if (dmemWEN) wen_cnt++;
      if (dmemREN || dmemWEN) begin
        chk("req_addr", dmemaddr, exp_addr);
        if (dmemWEN) chk("req_store", dmemstore, exp_store);
      end
      if (mem_done) begin : pop
        exp_t e;
        done_cnt++;
        done_cyc = cyc;
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_unexpected_done: got mem_done want none");
        end else begin
          e = sb.pop_front();
          chk("sb_load", dMemLoad, e.ld);
          chk("sb_flags", {29'd0, err_misaligned, err_timeout, err_protocol},
              {29'd0, e.mis, e.to, e.pr});
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr_cnt();
    stall_cnt = 0; ren_cnt = 0; wen_cnt = 0; done_cnt = 0; stall_start = 0; done_cyc = 0;
  endtask

  task automatic idle_inputs();
    valid_in = 1'b0; dren_in = 1'b0; dwen_in = 1'b0; halt_in = 1'b0; flush = 1'b0;
  endtask

  task automatic run_mem(input logic rd, input logic wr, input word_t a, input word_t sd,
                         input int hit_at, input word_t ld, input exp_t e);
    bit got;
    got = 1'b0;
    clr_cnt();
    exp_addr = a;
    exp_store = sd;
    sb.push_back(e);
    valid_in = 1'b1; dren_in = rd; dwen_in = wr; addr_in = a; store_in = sd;
    step();
    idle_inputs();
    for (int c = 1; c <= 20 && !got; c++) begin
      if (c == hit_at) begin
        dhit = 1'b1;
        dmemload = ld;
      end
      @(negedge CLK);
      got = mem_done;
      @(posedge CLK);
      #1;
      dhit = 1'b0;
      dmemload = 32'hDEAD_BEEF;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL op_wait: got no mem_done want mem_done within 20 cycles");
    end
  endtask

  task automatic chk_op(input string nm, input int ren, input int wen, input int stl, input int lat);
    chk({nm, "_ren"}, 32'(ren_cnt), 32'(ren));
    chk({nm, "_wen"}, 32'(wen_cnt), 32'(wen));
    chk({nm, "_stall"}, 32'(stall_cnt), 32'(stl));
    chk({nm, "_lat"}, 32'(done_cyc - stall_start), 32'(lat));
    chk({nm, "_done"}, 32'(done_cnt), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: got hang want finish");
    $fatal(1);
  end

  initial begin
    repeat (2) step();
    nRST = 1'b1;
    chk("rst_ctrl", {26'd0, dmemREN, dmemWEN, stall, mem_done, halt, err_misaligned},
        32'd0);
    chk("rst_err", {30'd0, err_timeout, err_protocol}, 32'd0);
    chk("rst_load", dMemLoad, 32'd0);
    chk("rst_addr", dmemaddr, 32'd0);

    // Load, 1-cycle hit
    run_mem(1'b1, 1'b0, 32'h0000_0040, 32'h0, 1, 32'hCAFE_F00D, '{32'hCAFE_F00D, 1'b0, 1'b0, 1'b0});
    chk_op("ld_hit1", 1, 0, 2, 2);

    // Store, hit on 4th wait cycle (coincides with the watchdog limit; hit wins)
    run_mem(1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4, 32'h5555_AAAA,
            '{32'hCAFE_F00D, 1'b0, 1'b0, 1'b0});
    chk_op("st_hit4", 0, 4, 5, 5);

    // Load that never hits: watchdog aborts after WL access cycles
    run_mem(1'b1, 1'b0, 32'h0000_0200, 32'h0, 0, 32'h0, '{32'h0, 1'b0, 1'b1, 1'b0});
    chk_op("ld_tmo", WL, 0, WL + 1, WL + 1);

    // Misaligned load: no request, completion next cycle
    run_mem(1'b1, 1'b0, 32'h0000_0042, 32'h0, 0, 32'h0, '{32'h0, 1'b1, 1'b1, 1'b0});
    chk_op("ld_misal", 0, 0, 1, 1);

    // Both dren and dwen: treated as store, protocol flag set
    run_mem(1'b1, 1'b1, 32'h0000_0080, 32'hAAAA_5555, 1, 32'h7777_7777,
            '{32'h0, 1'b1, 1'b1, 1'b1});
    chk_op("proto", 0, 1, 2, 2);

    // Non-memory op: same-cycle completion, no stall
    clr_cnt();
    sb.push_back('{32'h0, 1'b1, 1'b1, 1'b1});
    valid_in = 1'b1;
    step();
    idle_inputs();
    step();
    chk("nonmem_done", 32'(done_cnt), 32'd1);
    chk("nonmem_stall", 32'(stall_cnt), 32'd0);

    // Flushed load in IDLE: nothing happens
    clr_cnt();
    valid_in = 1'b1; dren_in = 1'b1; flush = 1'b1; addr_in = 32'h0000_0044;
    repeat (2) step();
    idle_inputs();
    step();
    chk("flush_req", 32'(ren_cnt + wen_cnt), 32'd0);
    chk("flush_done", 32'(done_cnt), 32'd0);
    chk("flush_stall", 32'(stall_cnt), 32'd0);

    // HALT then a load: halted, no further activity
    clr_cnt();
    sb.push_back('{32'h0, 1'b1, 1'b1, 1'b1});
    valid_in = 1'b1; halt_in = 1'b1;
    step();
    idle_inputs();
    chk("halt_set", 32'(halt), 32'd1);
    chk("halt_done", 32'(done_cnt), 32'd1);
    clr_cnt();
    valid_in = 1'b1; dren_in = 1'b1; addr_in = 32'h0000_0040;
    repeat (3) step();
    idle_inputs();
    chk("halted_req", 32'(ren_cnt + wen_cnt), 32'd0);
    chk("halted_done", 32'(done_cnt), 32'd0);
    chk("halted_stall", 32'(stall_cnt), 32'd0);
    chk("halt_sticky", 32'(halt), 32'd1);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("halt_rst", {28'd0, halt, err_misaligned, err_timeout, err_protocol}, 32'd0);
    chk("halt_rst_load", dMemLoad, 32'd0);

    // Reset in the middle of an access
    clr_cnt();
    exp_addr = 32'h0000_0300;
    valid_in = 1'b1; dren_in = 1'b1; addr_in = 32'h0000_0300;
    step();
    idle_inputs();
    step();
    chk("midrst_req_before", 32'(dmemREN), 32'd1);
    nRST = 1'b0;
    step();
    nRST = 1'b1;
    chk("midrst_ctrl", {28'd0, dmemREN, dmemWEN, stall, mem_done}, 32'd0);
    chk("midrst_addr", dmemaddr, 32'd0);
    repeat (3) step();
    chk("midrst_quiet", 32'(done_cnt), 32'd0);

    // Normal load after reset
    run_mem(1'b1, 1'b0, 32'h0000_0010, 32'h0, 2, 32'h0BAD_F00D, '{32'h0BAD_F00D, 1'b0, 1'b0, 1'b0});
    chk_op("ld_hit2", 2, 0, 3, 3);

    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
